// File: rtl/wb_skid_stage.sv
// wb_skid_stage: writeback pipeline register with valid/ready handshake and two-entry skid buffer
module wb_skid_stage #(
  parameter int WORD_SIZE       = 32,
  parameter int INSTR_TYPE_SZ   = 2,
  parameter int ROB_ENTRY_WITDH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_TYPE_SZ-1:0]   in_instruction_type,
  input  logic [WORD_SIZE-1:0]       in_pc,
  input  logic [WORD_SIZE-1:0]       in_result,
  input  logic [ROB_ENTRY_WITDH-1:0] in_rob_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_TYPE_SZ-1:0]   out_instruction_type,
  output logic [WORD_SIZE-1:0]       out_pc,
  output logic [WORD_SIZE-1:0]       out_result,
  output logic [ROB_ENTRY_WITDH-1:0] out_rob_id,
  output logic [1:0]                 occupancy
);
  localparam int W = INSTR_TYPE_SZ + 2 * WORD_SIZE + ROB_ENTRY_WITDH;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t r_state, w_next;
  logic [W-1:0] w_in, r_head, r_skid;
  logic w_accept, w_pop, w_load_head, w_load_skid, w_shift;
  assign w_in = {in_instruction_type, in_pc, in_result, in_rob_id};
  assign {out_instruction_type, out_pc, out_result, out_rob_id} = r_head;
  assign in_ready  = !reset && (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign occupancy = r_state;
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // A flushed cycle leaves data untouched; contents are don't-care once invalid.
  assign w_load_head = w_accept && !flush && (r_state == EMPTY || w_pop);
  assign w_load_skid = w_accept && !flush && r_state == ONE && !w_pop;
  assign w_shift     = !flush && r_state == FULL && w_pop;
  always_comb begin
    w_next = r_state;
    w_next = flush ? EMPTY :
             r_state == EMPTY ? (w_accept ? ONE : EMPTY) :
             r_state == ONE ? ((w_accept && !w_pop) ? FULL : (!w_accept && w_pop) ? EMPTY : ONE) :
             (w_pop ? ONE : FULL);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_head) r_head <= w_in;
      else if (w_shift) r_head <= r_skid;
      if (w_load_skid) r_skid <= w_in;
    end
  end
endmodule

// File: doc/wb_skid_stage.md
# wb_skid_stage

Parametrised writeback-stage pipeline register with a valid/ready handshake and a two-entry skid buffer. It sits between the memory stage (M5) and writeback and carries instruction type, PC, result and ROB id. Unlike a plain flop stage it can absorb writeback back-pressure without losing a beat, keeps full throughput, and supports a pipeline flush. in_ready is registered-derived, so there is no combinational path from out_ready to in_ready.

## Interface
- WORD_SIZE, 32, width of pc and result
- INSTR_TYPE_SZ, 2, width of instruction type
- ROB_ENTRY_WITDH, 3, width of ROB id
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discard all held and incoming beats
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat this cycle
- in_instruction_type  in  INSTR_TYPE_SZ  beat field
- in_pc  in  WORD_SIZE  beat field
- in_result  in  WORD_SIZE  beat field
- in_rob_id  in  ROB_ENTRY_WITDH  beat field
- out_valid  out  1  head beat valid
- out_ready  in  1  writeback consumes head beat this cycle
- out_instruction_type, out_pc, out_result, out_rob_id  out  as inputs  head beat fields
- occupancy  out  2  number of held beats (0..2)

## Operation
- Storage: head register (drives out_*) and skid register; state count ∈ {EMPTY=0, ONE=1, FULL=2}; occupancy = count.
- out_valid = (count != 0); in_ready = !reset && (count != FULL).
- accept = in_valid && in_ready; pop = out_valid && out_ready.
- EMPTY: accept → head ← in, ONE; else stay.
- ONE: accept && pop → head ← in, ONE; pop only → EMPTY; accept only → skid ← in, FULL; neither → stay.
- FULL: pop → head ← skid, ONE; else stay (in_ready is 0, so accept is impossible).
- Beats leave in arrival order; no beat is duplicated or dropped except by flush or reset.
- flush has priority over accept and pop: next state is EMPTY; a beat offered in the flush cycle is discarded, and a pop in the flush cycle still counts as consumed by downstream.
- Data registers update only on accept or a FULL→ONE shift; they otherwise hold their values, including after a flush (content is don't-care when not valid).
- Field widths pass through unchanged; no arithmetic on data.

## Timing
- Reset (async assert, any time, including mid-transfer): count=EMPTY immediately; out_valid=0, occupancy=0, in_ready=0 while reset is high; all out_* data = 0. After deassertion, in_ready=1 on the same cycle.
- Latency: a beat accepted at edge t into EMPTY is visible on out_* after edge t (one cycle).
- Throughput: 1 beat/cycle with out_ready held high; occupancy stays ≤1.
- Back-pressure: with out_ready low, two beats are absorbed; in_ready drops the cycle after the second accept.
- FULL + pop: in_ready returns to 1 the cycle after the pop, and the skid beat becomes head.
- flush: out_valid=0 and in_ready=1 the cycle after flush (unless reset).

## Test plan
- Reset mid-stream: occupancy=2, assert reset between edges → out_valid=0, occupancy=0 and out_pc=0 immediately, without waiting for clk.
- Streaming: 8 beats, pc=0x100..0x11C, out_ready=1 → out_pc matches 1 cycle later each cycle, occupancy never exceeds 1.
- Stall: out_ready=0, offer pc=0x40, 0x44, 0x48 → first two accepted, in_ready=0, occupancy=2. Raise out_ready → outputs 0x40 then 0x44; 0x48 is accepted when in_ready=1, with order preserved.
- Simultaneous accept+pop at ONE: head pc=0x10, offer 0x14 with out_ready=1 → next cycle head=0x14, occupancy=1.
- Flush at FULL with in_valid=1 (pc=0x80) → next cycle out_valid=0, occupancy=0, 0x80 never appears.
- Random valid/ready for 10k cycles → scoreboard confirms in-order, lossless delivery of all fields (rob_id, type, pc, result).
